calculator_core: RTL and testbench

//  Parametrised calculator datapath that pairs with the calculator bench interface.

---
 rtl/calculator_core.sv | 115 +++++++++++
 tb/tb_calculator_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/calculator_core.sv
// Unsigned add/sub/mul/div calculator core with valid/ready handshakes on both sides.
// add/sub/mul and div-by-zero return after 1 cycle, division after WIDTH cycles; the result is held until consumed.
module calculator_core #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   operand_A,
   input  logic [WIDTH-1:0]   operand_B,
   input  logic [1:0]         op_code,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               out_err
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, rem_q;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q, out_valid_q, out_err_q;
   logic [RW-1:0]    result_q;

   logic [WIDTH:0]   trial_d, diff_d;
   logic             ge_d;
   logic [WIDTH-1:0] rem_d, quot_d;
   logic [RW-1:0]    arith_d;

   // One restoring step: a_q shifts the dividend out MSB first and the quotient bits in at the LSB.
   always_comb begin
      trial_d = {rem_q, a_q[WIDTH-1]};
      diff_d  = trial_d - {1'b0, b_q};
      ge_d    = (trial_d >= {1'b0, b_q});
      rem_d   = ge_d ? diff_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
      quot_d  = {a_q[WIDTH-2:0], ge_d};
      case (op_q)
         2'b00:   arith_d = RW'(a_q) + RW'(b_q);
         2'b01:   arith_d = RW'(a_q) - RW'(b_q);
         default: arith_d = RW'(a_q) * RW'(b_q);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         result_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= operand_A;
                  b_q        <= operand_B;
                  op_q       <= op_code;
                  rem_q      <= '0;
                  cnt_q      <= CW'(WIDTH);
                  in_ready_q <= 1'b0;
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               if (op_q != 2'b11) begin
                  result_q    <= arith_d;
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else if (b_q == '0) begin
                  result_q    <= '1;
                  out_err_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  a_q   <= quot_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     result_q    <= {rem_d, quot_d};
                     out_err_q   <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_calculator_core.sv
// Bench for calculator_core: directed cases on an 8-bit core, random traffic on 8- and 16-bit cores.
module tb_calculator_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv8, iv16, ordy;
   logic [15:0] opa, opb;
   logic [1:0]  opc;
   logic        ir8, ov8, err8, ir16, ov16, err16;
   logic [15:0] res8;
   logic [31:0] res16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   calculator_core #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .operand_A(opa[7:0]), .operand_B(opb[7:0]), .op_code(opc),
      .out_valid(ov8), .out_ready(ordy), .result(res8), .out_err(err8)
   );

   calculator_core #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .operand_A(opa), .operand_B(opb), .op_code(opc),
      .out_valid(ov16), .out_ready(ordy), .result(res16), .out_err(err16)
   );

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic reduced modulo 2^(2w).
   task automatic ref_op(input int w, input logic [1:0] op, input longint unsigned a,
                         input longint unsigned b, output longint unsigned r,
                         output bit e, output int lat);
      longint unsigned m;
      m   = (64'd1 << (2 * w)) - 1;
      e   = 1'b0;
      lat = 1;
      case (op)
         2'd0: r = a + b;
         2'd1: r = a - b;
         2'd2: r = a * b;
         default: begin
            if (b == 0) begin
               r = m;
               e = 1'b1;
            end else begin
               r   = ((a % b) << w) | (a / b);
               lat = w;
            end
         end
      endcase
      r = r & m;
   endtask

   function automatic logic cur_ir(input bit wide);
      return wide ? ir16 : ir8;
   endfunction
   function automatic logic cur_ov(input bit wide);
      return wide ? ov16 : ov8;
   endfunction
   function automatic logic cur_err(input bit wide);
      return wide ? err16 : err8;
   endfunction
   function automatic longint unsigned cur_res(input bit wide);
      return wide ? longint'(res16) : longint'(res8);
   endfunction

   task automatic set_iv(input bit wide, input logic v);
      if (wide) iv16 = v;
      else      iv8  = v;
   endtask

   task automatic run_op(input string tag, input bit wide, input logic [1:0] op,
                         input logic [15:0] a_in, input logic [15:0] b_in, input int stall);
      int              w, lat, t;
      logic [15:0]     a, b;
      longint unsigned er;
      bit              ee;
      int              el;
      w = wide ? 16 : 8;
      a = wide ? a_in : {8'h00, a_in[7:0]};
      b = wide ? b_in : {8'h00, b_in[7:0]};
      ref_op(w, op, a, b, er, ee, el);

      @(negedge clk);
      t = 0;
      while (!cur_ir(wide) && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk({tag, ":in_ready"}, cur_ir(wide), 1);
      if (!cur_ir(wide)) return;

      opa = a; opb = b; opc = op;
      set_iv(wide, 1'b1);
      ordy = (stall == 0);
      @(posedge clk);
      #1;
      set_iv(wide, 1'b0);
      opa = 16'($urandom); opb = 16'($urandom); opc = 2'($urandom);

      lat = 0;
      while (!cur_ov(wide) && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ":latency"}, lat, el);
      chk({tag, ":result"}, cur_res(wide), er);
      chk({tag, ":err"}, cur_err(wide), ee);
      chk({tag, ":busy"}, cur_ir(wide), 0);

      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         set_iv(wide, 1'($urandom));
         opa = 16'($urandom); opb = 16'($urandom); opc = 2'($urandom);
         @(posedge clk);
         #1;
         chk({tag, ":hold_vld"}, cur_ov(wide), 1);
         chk({tag, ":hold_rdy"}, cur_ir(wide), 0);
         chk({tag, ":hold_res"}, cur_res(wide), er);
      end

      @(negedge clk);
      ordy = 1'b1;
      @(posedge clk);
      #1;
      set_iv(wide, 1'b0);
      chk({tag, ":released"}, cur_ov(wide), 0);
      chk({tag, ":idle_rdy"}, cur_ir(wide), 1);
   endtask

   initial begin
      int bad;
      rst_n = 1'b0; iv8 = 1'b0; iv16 = 1'b0; ordy = 1'b0;
      opa = '0; opb = '0; opc = '0;
      #12;
      chk("rst:in_ready", ir8, 1);
      chk("rst:out_valid", ov8, 0);
      chk("rst:result", res8, 0);
      chk("rst:err", err8, 0);
      chk("rst16:in_ready", ir16, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_ff_01", 0, 2'd0, 16'h00FF, 16'h0001, 0);
      run_op("sub_3_5",   0, 2'd1, 16'h0003, 16'h0005, 0);
      run_op("mul_ff_ff", 0, 2'd2, 16'h00FF, 16'h00FF, 0);
      run_op("div_100_7", 0, 2'd3, 16'd100,  16'd7,    0);
      run_op("div_5_0",   0, 2'd3, 16'd5,    16'd0,    0);
      run_op("add_1_1",   0, 2'd0, 16'd1,    16'd1,    0);
      run_op("backpress", 0, 2'd2, 16'h00C8, 16'h0009, 5);

      // Abort a division partway through with reset.
      @(negedge clk);
      opa = 16'h00FF; opb = 16'h0003; opc = 2'd3; iv8 = 1'b1;
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort:out_valid", ov8, 0);
      chk("abort:in_ready", ir8, 1);
      chk("abort:result", res8, 0);
      chk("abort:err", err8, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (ov8) bad++;
      end
      chk("abort:no_valid", bad, 0);
      run_op("add_2_3", 0, 2'd0, 16'd2, 16'd3, 0);

      for (int i = 0; i < 40; i++)
         run_op("rnd8", 0, 2'($urandom), 16'($urandom),
                ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom), $urandom_range(0, 2));
      for (int i = 0; i < 60; i++)
         run_op("rnd16", 1, 2'($urandom), 16'($urandom),
                ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom), $urandom_range(0, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
